// File: rtl/sws_multi_pwm.sv
// sws_multi_pwm: multi-channel PWM / sigma-delta generator
// with a strobe-based register write port and double-buffered duties.
module sws_multi_pwm #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [3:0] NCH = 4'(CHANNELS);

  logic [2:0] sync;
  logic [1:0] settle;
  logic       armed;
  logic       wr;
  logic       wr_ctrl;
  logic       wr_duty;
  logic       mode_chg;

  logic [3:0] pre;
  logic [3:0] pcnt;
  logic       mode;
  logic       tick;
  logic       wrap;
  logic [WIDTH-1:0] cnt;

  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];
  logic [WIDTH-1:0] acc    [CHANNELS];
  logic [WIDTH:0]   sum    [CHANNELS];
  logic [CHANNELS-1:0] chan;

  wire unused = &{1'b0, ui_in[7:6], uio_in};

  // A strobe seen high straight out of reset must drop
  // before it can arm the edge detector.
  assign wr = sync[1] & ~sync[2] & armed;
  assign wr_ctrl = wr & ui_in[5];
  assign wr_duty = wr & ~ui_in[5] & ({1'b0, ui_in[2:0]} < NCH);
  assign mode_chg = wr_ctrl & (ui_in[4] != mode);

  assign tick = ena & (pcnt >= pre);
  assign wrap = tick & (cnt == CMAX) & ~mode_chg;

  // strobe synchroniser, delay flop and arming after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync   <= '0;
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      sync   <= {sync[1:0], ui_in[3]};
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & ~sync[1]);
    end
  end

  // control register: prescale and global mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre  <= '0;
      mode <= 1'b0;
    end else if (wr_ctrl) begin
      pre  <= uio_in[3:0];
      mode <= ui_in[4];
    end
  end

  // prescaler: one tick every pre+1 enabled clocks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (ena) begin
      pcnt <= tick ? 4'd0 : pcnt + 4'd1;
    end
  end

  // period counter; a mode switch restarts the period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (mode_chg) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  // accumulator sums for sigma-delta mode
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, active[i]};
    end
  end

  // per-channel duty buffers, accumulators and output flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        acc[i]    <= '0;
      end
      chan <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_duty && ui_in[2:0] == 3'(i)) begin
          shadow[i] <= uio_in[WIDTH-1:0];
        end
        if (wrap) begin
          active[i] <= shadow[i];
        end
        if (mode_chg) begin
          acc[i] <= '0;
        end else if (tick && mode) begin
          acc[i] <= sum[i][WIDTH-1:0];
        end
        if (ena) begin
          if (mode) begin
            if (tick) begin
              chan[i] <= sum[i][WIDTH];
            end
          end else begin
            chan[i] <= cnt < active[i];
          end
        end
      end
    end
  end

  // channel outputs on the low bits, rest tied low
  always_comb begin
    uo_out = '0;
    uo_out[CHANNELS-1:0] = chan;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: doc/sws_multi_pwm.md
SWS_MULTI_PWM -- requirements
Module: sws_multi_pwm

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of output channels, legal 1..8.
REQ-002 SHALL have parameter WIDTH, default 8: duty/counter bit width, legal 4..8.
REQ-003 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port ena, input, 1: count enable; 0 freezes prescaler, counter and accumulators.
REQ-006 SHALL have port ui_in, input, 8: [2:0] address, [3] write strobe, [4] mode (0 PWM, 1 sigma-delta), [5] control-register select, [7:6] unused.
REQ-007 SHALL have port uio_in, input, 8: write data.
REQ-008 SHALL have port uo_out, output, 8: [CHANNELS-1:0] channel outputs, remaining bits 0.
REQ-009 SHALL have port uio_out, output, 8: constant 0.
REQ-010 SHALL have port uio_oe, output, 8: constant 0 (all uio pins inputs).

Function
REQ-011 SHALL pass ui_in[3] through a 2-flop synchroniser plus a delay flop; a write SHALL occur on the single cycle where the synchronised strobe is 1 and the delayed copy is 0 (rising edge, 2 cycles after strobe rise).
REQ-012 SHALL capture address, mode, select and data from ui_in/uio_in on the write cycle; the host SHALL hold them stable from strobe rise until 4 cycles after.
REQ-013 Write with ui_in[5]=1 SHALL load prescale register PRE <= uio_in[3:0] and global mode <= ui_in[4]; address ignored.
REQ-014 Write with ui_in[5]=0 and address < CHANNELS SHALL load shadow duty of that channel <= uio_in[WIDTH-1:0]; address >= CHANNELS SHALL be ignored without side effect.
REQ-015 Prescaler SHALL produce one tick every PRE+1 enabled clocks (PRE=0: every clock).
REQ-016 Period counter CNT (WIDTH bits) SHALL increment on each tick, wrapping 2^WIDTH-1 -> 0.
REQ-017 On the tick where CNT wraps to 0, every active duty SHALL load from its shadow (double buffering); mid-period writes SHALL not alter the current period.
REQ-018 Write and wrap on the same cycle: the wrap SHALL load the pre-write shadow; the new value takes effect at the following wrap.
REQ-019 PWM mode: channel output SHALL be registered (CNT < active duty), 1-cycle latency from CNT; duty 0 -> constant 0; duty 2^WIDTH-1 -> high 2^WIDTH-1 of 2^WIDTH ticks.
REQ-020 Sigma-delta mode: per channel, a WIDTH+1-bit accumulator SHALL, on each tick, compute {carry, acc} = acc + active duty; registered output = carry.
REQ-021 Mode change SHALL clear all accumulators and CNT on the write cycle; shadow and active duties retained.
REQ-022 ena=0 SHALL hold all outputs at their current values; writes still accepted.
REQ-023 Period length in clocks SHALL be (PRE+1)*2^WIDTH.

Reset
REQ-024 rst_n=0 at a clock edge SHALL clear PRE, mode, CNT, prescaler, all shadow/active duties, accumulators and synchroniser flops; uo_out=0 from the next cycle.
REQ-025 Reset asserted mid-period or mid-write SHALL discard the pending write; no output glitch other than going to 0.
REQ-026 A strobe held high across reset release SHALL not generate a write until it falls and rises again.

Verification (CHANNELS=4, WIDTH=8, ena=1 unless stated)
REQ-027 PRE=0, PWM, write ch0 duty 64 -> from first wrap after write, ch0 high 64 clocks of every 256; ch1..3 stay 0; uo_out[7:4]=0.
REQ-028 Duties ch0=0, ch1=255, ch2=128 -> ch0 constant 0, ch1 low exactly 1 clock per 256, ch2 50% with 128-clock high.
REQ-029 Control write PRE=3, ch3 duty 128 -> period 1024 clocks, ch3 high 512.
REQ-030 Sigma-delta mode, ch0 duty 128, PRE=0 -> after first wrap ch0 toggles every clock (1,0,1,0...); duty 64 -> one 1 every 4 clocks.
REQ-031 Write ch0 duty 200 at CNT=10 of period with duty 64 -> current period still 64 high; next period 200 high; write to address 5 -> no register changes.
REQ-032 rst_n low 1 cycle mid-period with strobe held high -> uo_out=0 next cycle, all duties 0, no write until strobe re-toggled; ena=0 for 100 clocks -> outputs and CNT frozen, resume exactly.
